// File: rtl/serial_full_subtractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_full_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// Rev 1.0
// ----------------------------------------------------------------------------
module serial_full_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             bit_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d_bit, br_nxt;

  assign d_bit  = a_sr[0] ^ b_sr[0] ^ borrow;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == C_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
      bit_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            borrow <= bin_in;
            cnt    <= '0;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB so bit 0 lands at index 0 after WIDTH shifts.
          diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          borrow  <= br_nxt;
          bit_out <= d_bit;
          cnt     <= cnt + CW'(1);
        end
        DONE: begin
          diff_out   <= diff_sr;
          borrow_out <= borrow;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
